// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone classic arbiter. Round-robin grant, held for a
// whole bus cycle, with a per-transfer watchdog that errors a strobe the slave never acks.
module wb_arbiter_2to1 #(
   parameter int ADDR_WIDTH = 15,
   parameter int TIMEOUT    = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic                  m0_we_i,
   input  logic [3:0]            m0_sel_i,
   input  logic [31:0]           m0_dat_i,
   output logic [31:0]           m0_dat_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic                  m1_we_i,
   input  logic [3:0]            m1_sel_i,
   input  logic [31:0]           m1_dat_i,
   output logic [31:0]           m1_dat_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic [31:0]           s_dat_o,
   input  logic [31:0]           s_dat_i,
   input  logic                  s_ack_i,
   output logic                  dbg_busy,
   output logic                  dbg_gnt
);

   // Handshake: a transfer completes on any cycle where the owner's cyc and stb are high
   // and the slave returns ack; ack and err are passed straight through to the owner only.
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t         state, state_nx;
   logic           gnt, gnt_nx;
   logic           last, last_nx;
   logic [WDW-1:0] wdog, wdog_nx;
   logic           err_pulse, err_nx;
   logic           mg_cyc, mg_stb;

   assign mg_cyc   = gnt ? m1_cyc_i : m0_cyc_i;
   assign mg_stb   = gnt ? m1_stb_i : m0_stb_i;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign dbg_busy = (state == BUSY);
   assign dbg_gnt  = gnt;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         wdog      <= '0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nx;
         gnt       <= gnt_nx;
         last      <= last_nx;
         wdog      <= wdog_nx;
         err_pulse <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      last_nx  = last;
      wdog_nx  = wdog;
      err_nx   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_adr_o  = m0_adr_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      case (state)
         IDLE: begin
            wdog_nx = '0;
            // On a tie the master that was not served last wins.
            if (m0_cyc_i && (!m1_cyc_i || last)) begin
               state_nx = BUSY;
               gnt_nx   = 1'b0;
            end else if (m1_cyc_i) begin
               state_nx = BUSY;
               gnt_nx   = 1'b1;
            end
         end
         BUSY: begin
            if (gnt) begin
               s_adr_o  = m1_adr_i;
               s_we_o   = m1_we_i;
               s_sel_o  = m1_sel_i;
               s_dat_o  = m1_dat_i;
               m1_ack_o = s_ack_i & ~err_pulse;
               m1_err_o = err_pulse;
            end else begin
               m0_ack_o = s_ack_i & ~err_pulse;
               m0_err_o = err_pulse;
            end
            s_cyc_o = mg_cyc;
            s_stb_o = mg_stb & ~err_pulse;
            if (!mg_cyc) begin
               state_nx = IDLE;
               last_nx  = gnt;
               wdog_nx  = '0;
            end else if (s_stb_o && !s_ack_i) begin
               if (wdog == WD_LAST) begin
                  err_nx  = 1'b1;
                  wdog_nx = '0;
               end else begin
                  wdog_nx = wdog + 1'b1;
               end
            end else begin
               wdog_nx = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Bench for wb_arbiter_2to1: directed scenarios plus random rounds, checked by
// slave-side and master-side monitors against queues filled by a round-robin/memory model.
module tb_wb_arbiter_2to1;

   localparam int AW = 15;
   localparam int TO = 8;
   localparam logic [AW-1:0] DEAD_ADR = 15'h7FFC;
   localparam logic [AW-1:0] LATE_ADR = 15'h7FF8;

   logic          clk = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          m_cyc[2], m_stb[2], m_we[2];
   logic [AW-1:0] m_adr[2];
   logic [3:0]    m_sel[2];
   logic [31:0]   m_wdat[2], m_rdat[2];
   logic          m_ack[2], m_err[2];
   logic          s_cyc_o, s_stb_o, s_we_o, s_ack, dbg_busy, dbg_gnt;
   logic [AW-1:0] s_adr_o;
   logic [3:0]    s_sel_o;
   logic [31:0]   s_dat_o, s_rdat;

   logic [31:0] mem[8192];
   logic [31:0] ref_mem[8192];
   logic [51:0] slv_q[$];
   logic [35:0] resp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          model_last = 1;
   int          late_cnt;

   always #5 clk = ~clk;

   wb_arbiter_2to1 #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_adr_i(m_adr[0]), .m0_we_i(m_we[0]),
      .m0_sel_i(m_sel[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m_rdat[0]),
      .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_adr_i(m_adr[1]), .m1_we_i(m_we[1]),
      .m1_sel_i(m_sel[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m_rdat[1]),
      .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_rdat), .s_ack_i(s_ack),
      .dbg_busy(dbg_busy), .dbg_gnt(dbg_gnt)
   );

   // Slave: SRAM acking one cycle after a strobe; DEAD never acks, LATE acks on the 9th cycle.
   always @(posedge clk) begin
      if (wb_rst_i) begin
         s_ack    <= 1'b0;
         late_cnt <= 0;
      end else begin
         s_ack <= 1'b0;
         if (s_cyc_o && s_stb_o && !s_ack) begin
            if (s_adr_o == LATE_ADR) begin
               late_cnt <= late_cnt + 1;
               if (late_cnt == TO - 1) s_ack <= 1'b1;
            end else if (s_adr_o != DEAD_ADR) begin
               s_ack  <= 1'b1;
               s_rdat <= mem[s_adr_o[14:2]];
               if (s_we_o)
                  for (int b = 0; b < 4; b++)
                     if (s_sel_o[b]) mem[s_adr_o[14:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
            end
         end else begin
            late_cnt <= 0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event seen where none was expected", name);
   endtask

   // Reference model: serialized transfers against a plain word memory.
   task automatic expect_cycle(input int id, input int n, input logic we, input logic [AW-1:0] adr0,
                               input logic [3:0] sel, input logic [31:0] d0, input logic [31:0] ds);
      logic [AW-1:0] a;
      logic [31:0]   d;
      for (int k = 0; k < n; k++) begin
         a = adr0 + AW'(4 * k);
         d = d0 + ds * k;
         if (we) begin
            slv_q.push_back({a, 1'b1, sel, d});
            for (int b = 0; b < 4; b++)
               if (sel[b]) ref_mem[a[14:2]][8*b +: 8] = d[8*b +: 8];
            resp_q.push_back({id[0], 1'b1, 1'b0, 1'b0, 32'h0});
         end else begin
            slv_q.push_back({a, 1'b0, sel, 32'h0});
            resp_q.push_back({id[0], 1'b1, 1'b0, 1'b1, ref_mem[a[14:2]]});
         end
      end
      model_last = id;
   endtask

   task automatic expect_err(input int id);
      resp_q.push_back({id[0], 1'b0, 1'b1, 1'b0, 32'h0});
      model_last = id;
   endtask

   task automatic master_cycle(input int id, input int n, input logic we, input logic [AW-1:0] adr0,
                               input logic [3:0] sel, input logic [31:0] d0, input logic [31:0] ds);
      int  budget;
      logic got_err;
      @(posedge clk); #1;
      m_cyc[id] = 1'b1;
      m_we[id]  = we;
      m_sel[id] = sel;
      for (int k = 0; k < n; k++) begin
         m_stb[id]  = 1'b1;
         m_adr[id]  = adr0 + AW'(4 * k);
         m_wdat[id] = d0 + ds * k;
         budget = 0;
         do begin
            @(negedge clk);
            budget++;
         end while (!(m_ack[id] || m_err[id]) && budget < 100);
         if (budget >= 100) flag($sformatf("m%0d_timeout", id));
         got_err = m_err[id];
         @(posedge clk); #1;
         m_stb[id] = 1'b0;
         if (got_err) break;
      end
      m_cyc[id] = 1'b0;
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 wb_rst_i = 1'b0;
      model_last = 1;
   endtask

   task automatic wait_neg(input int which, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!((which == 0) ? s_stb_o : (m_ack[0] || m_err[0])) && cycles < 60);
      if (cycles >= 60) flag("wait_budget");
   endtask

   // Slave-side monitor: every completed slave transfer in order.
   always @(negedge clk) begin
      if (!wb_rst_i && s_cyc_o && s_stb_o && s_ack) begin
         if (slv_q.size() == 0) flag("slave_xfer_unexpected");
         else check("slave_xfer", {s_adr_o, s_we_o, s_sel_o, s_we_o ? s_dat_o : 32'h0},
                    slv_q.pop_front());
      end
   end

   // Master-side monitor: every ack or err delivered to either master.
   always @(negedge clk) begin
      logic [35:0] e;
      if (!wb_rst_i) begin
         if ((m_ack[0] || m_err[0]) && (m_ack[1] || m_err[1])) flag("both_masters_resp");
         for (int i = 0; i < 2; i++) begin
            if (m_ack[i] || m_err[i]) begin
               if (resp_q.size() == 0) flag("master_resp_unexpected");
               else begin
                  e = resp_q.pop_front();
                  check("master_resp", {i[0], m_ack[i], m_err[i], e[32], e[32] ? m_rdat[i] : 32'h0}, e);
               end
            end
         end
      end
   end

   initial begin
      int c, idle, gap, extra, mode, first;
      int rn[2];
      logic rwe[2];
      logic [AW-1:0] radr[2];
      logic [3:0] rsel[2];
      logic [31:0] rd0[2], rds[2];
      for (int i = 0; i < 8192; i++) begin
         mem[i]     = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
         ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      end
      mem[1] = 32'hDEADBEEF;
      ref_mem[1] = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0; m_adr[i] = '0; m_sel[i] = '0; m_wdat[i] = '0;
      end
      do_reset();
      @(negedge clk);
      check("reset_s_cyc", s_cyc_o, 0);
      check("reset_s_stb", s_stb_o, 0);
      check("reset_busy", dbg_busy, 0);

      // Single read with latency checks.
      expect_cycle(0, 1, 1'b0, 15'h0004, 4'hF, 0, 0);
      fork
         master_cycle(0, 1, 1'b0, 15'h0004, 4'hF, 0, 0);
         begin
            @(posedge clk);
            @(negedge clk); check("t1_stb_req_cycle", s_stb_o, 0);
            @(negedge clk); check("t1_stb_rise", s_stb_o, 1);
            @(negedge clk); check("t1_ack_lat", m_ack[0], 1);
            check("t1_rdata", m_rdat[0], 32'hDEADBEEF);
            check("t1_m1_ack", m_ack[1], 0);
         end
      join
      repeat (2) @(posedge clk);

      // Simultaneous requests alternate with one IDLE cycle between owners.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         expect_cycle(0, 1, 1'b0, AW'(8 * r), 4'hF, 0, 0);
         expect_cycle(1, 1, 1'b0, AW'(8 * r + 4), 4'hF, 0, 0);
         fork
            master_cycle(0, 1, 1'b0, AW'(8 * r), 4'hF, 0, 0);
            master_cycle(1, 1, 1'b0, AW'(8 * r + 4), 4'hF, 0, 0);
            begin
               wait_neg(1, c);
               idle = 0; gap = 0;
               do begin
                  @(negedge clk);
                  gap++;
                  if (!dbg_busy) idle++;
               end while (!m_ack[1] && gap < 50);
               check("t2_idle_between", idle, 1);
               check("t2_ack_gap", gap, 4);
            end
         join
         repeat (2) @(posedge clk);
      end

      // m1 burst of three writes holds the bus while m0 waits.
      expect_cycle(1, 3, 1'b1, 15'h0100, 4'b0011, 32'h11111111, 32'h11111111);
      expect_cycle(0, 1, 1'b0, 15'h0104, 4'hF, 0, 0);
      fork
         master_cycle(1, 3, 1'b1, 15'h0100, 4'b0011, 32'h11111111, 32'h11111111);
         begin
            repeat (2) @(posedge clk);
            master_cycle(0, 1, 1'b0, 15'h0104, 4'hF, 0, 0);
         end
      join
      repeat (2) @(posedge clk);

      // Watchdog: slave never acks; m1 waits and is served after.
      expect_err(0);
      expect_cycle(1, 1, 1'b0, 15'h0020, 4'hF, 0, 0);
      fork
         master_cycle(0, 1, 1'b0, DEAD_ADR, 4'hF, 0, 0);
         begin
            repeat (4) @(posedge clk);
            master_cycle(1, 1, 1'b0, 15'h0020, 4'hF, 0, 0);
         end
         begin
            wait_neg(0, c);
            wait_neg(1, c);
            check("t4_err_delay", c, TO);
            check("t4_stb_in_err", s_stb_o, 0);
            extra = 0;
            repeat (20) begin
               @(negedge clk);
               if (m_err[0]) extra++;
            end
            check("t4_err_once", extra, 0);
         end
      join
      repeat (2) @(posedge clk);

      // Ack arriving in the error cycle is discarded.
      expect_err(0);
      fork
         master_cycle(0, 1, 1'b0, LATE_ADR, 4'hF, 0, 0);
         begin
            wait_neg(1, c);
            check("t6_ack_vs_err_ack", m_ack[0], 0);
            check("t6_ack_vs_err_err", m_err[0], 1);
         end
      join
      repeat (2) @(posedge clk);

      // Reset while m1 owns the bus mid-strobe.
      @(posedge clk); #1;
      m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0; m_sel[1] = 4'hF; m_adr[1] = DEAD_ADR;
      repeat (3) @(posedge clk);
      #1;
      wb_rst_i = 1'b1;
      m_adr[1] = 15'h0040;
      m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_sel[0] = 4'hF; m_adr[0] = 15'h0044;
      @(posedge clk); #1;
      wb_rst_i = 1'b0;
      model_last = 1;
      expect_cycle(0, 1, 1'b0, 15'h0044, 4'hF, 0, 0);
      expect_cycle(1, 1, 1'b0, 15'h0040, 4'hF, 0, 0);
      @(negedge clk);
      check("t5_s_cyc_after_rst", s_cyc_o, 0);
      check("t5_idle_after_rst", dbg_busy, 0);
      check("t5_m1_ack_after_rst", {m_ack[1], m_err[1]}, 0);
      fork
         master_cycle(0, 1, 1'b0, 15'h0044, 4'hF, 0, 0);
         master_cycle(1, 1, 1'b0, 15'h0040, 4'hF, 0, 0);
      join
      repeat (2) @(posedge clk);

      // Random rounds.
      for (int r = 0; r < 40; r++) begin
         mode = $urandom_range(0, 2);
         for (int i = 0; i < 2; i++) begin
            rn[i]   = $urandom_range(1, 3);
            rwe[i]  = 1'($urandom_range(0, 1));
            radr[i] = AW'($urandom_range(0, 60) * 4);
            rsel[i] = 4'($urandom_range(1, 15));
            rd0[i]  = $urandom;
            rds[i]  = $urandom;
         end
         if (mode == 2) begin
            first = (model_last == 1) ? 0 : 1;
            expect_cycle(first, rn[first], rwe[first], radr[first], rsel[first], rd0[first], rds[first]);
            expect_cycle(1 - first, rn[1-first], rwe[1-first], radr[1-first], rsel[1-first],
                         rd0[1-first], rds[1-first]);
            fork
               master_cycle(0, rn[0], rwe[0], radr[0], rsel[0], rd0[0], rds[0]);
               master_cycle(1, rn[1], rwe[1], radr[1], rsel[1], rd0[1], rds[1]);
            join
         end else begin
            expect_cycle(mode, rn[mode], rwe[mode], radr[mode], rsel[mode], rd0[mode], rds[mode]);
            master_cycle(mode, rn[mode], rwe[mode], radr[mode], rsel[mode], rd0[mode], rds[mode]);
         end
         repeat ($urandom_range(1, 3)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      check("slave_queue_drained", slv_q.size(), 0);
      check("resp_queue_drained", resp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
